// File: rtl/motor_duty_mixer_pkg.sv
// Purpose: shared types, constants and the slew step helper for the motor duty mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package motor_duty_mixer_pkg;

    // Per-channel bridge state. The encoding is fixed so that it reads the same in any dump.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } chan_state_e;

    // Width of the dead-time counter; holds DEAD_TICKS in the range 0..255.
    localparam int CNT_W  = 8;

    // Working width of the slew helper; callers zero-extend into it and truncate the result.
    localparam int SLEW_W = 32;

    // Move cur toward goal by at most step. A step of 0 jumps straight to goal.
    function automatic logic [SLEW_W-1:0] slew(input logic [SLEW_W-1:0] cur,
                                               input logic [SLEW_W-1:0] goal,
                                               input logic [SLEW_W-1:0] step);
        logic [SLEW_W-1:0] res;
        res = goal;
        if (step != '0) begin
            if (goal >= cur) begin
                if ((goal - cur) > step) res = cur + step;
            end else begin
                if ((cur - goal) > step) res = cur - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_duty_mixer_if.sv
// Purpose: command/control/duty bundle between the PID outputs, the mixer and the PWM pairs.
// Latency: n/a (wires only).
// Backpressure: none; the mixer accepts a tick on every UPD_STB cycle.
// Signals: EN, UPD_STB, CMD_A/CMD_B (NCH x DW signed), SLEW_STEP, DEADBAND (DUTY_W),
//          DUTY_P/DUTY_N (NCH x DUTY_W), DIR (NCH), VALID.
interface motor_duty_mixer_if #(
    parameter int NCH    = 2,
    parameter int DW     = 32,
    parameter int DUTY_W = 16
);
    logic                    EN;
    logic                    UPD_STB;
    logic [NCH*DW-1:0]       CMD_A;
    logic [NCH*DW-1:0]       CMD_B;
    logic [DUTY_W-1:0]       SLEW_STEP;
    logic [DUTY_W-1:0]       DEADBAND;
    logic [NCH*DUTY_W-1:0]   DUTY_P;
    logic [NCH*DUTY_W-1:0]   DUTY_N;
    logic [NCH-1:0]          DIR;
    logic                    VALID;

    // Command source side.
    modport master (
        output EN, UPD_STB, CMD_A, CMD_B, SLEW_STEP, DEADBAND,
        input  DUTY_P, DUTY_N, DIR, VALID
    );

    // Mixer side.
    modport slave (
        input  EN, UPD_STB, CMD_A, CMD_B, SLEW_STEP, DEADBAND,
        output DUTY_P, DUTY_N, DIR, VALID
    );
endinterface

// File: rtl/motor_duty_mixer_slew_chan.sv
// Purpose: one channel: A-B difference, scale/saturate/deadband, slew-limited bridge FSM with dead time.
// Latency: 3 CLK from the strobe edge to registered duty outputs.
// Backpressure: none; one tick accepted per enabled stage strobe, EN=0 clears every stage.
// Ports: CLK/RST, en, s1_en/s2_en/s3_en stage strobes, cmd_a/cmd_b, slew_step, deadband,
//        duty_p/duty_n/dir registered outputs.
module duty_slew_chan
    import motor_duty_mixer_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DUTY_W     = 16,
    parameter int SHIFT      = 15,
    parameter int DUTY_MAX   = 9999,
    parameter int DUTY_MIN   = 1,
    parameter int DEAD_TICKS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              s1_en,
    input  logic              s2_en,
    input  logic              s3_en,
    input  logic [DW-1:0]     cmd_a,
    input  logic [DW-1:0]     cmd_b,
    input  logic [DUTY_W-1:0] slew_step,
    input  logic [DUTY_W-1:0] deadband,
    output logic [DUTY_W-1:0] duty_p,
    output logic [DUTY_W-1:0] duty_n,
    output logic              dir
);

    localparam logic [DUTY_W-1:0] DUTY_MIN_V = DUTY_W'(DUTY_MIN);

    // Stage 1: difference one bit wider than the commands so it can never wrap.
    logic [DW:0] diff_d, diff_q;

    always_comb begin
        diff_d = diff_q;
        if (!en) begin
            diff_d = '0;
        end else if (s1_en) begin
            diff_d = {cmd_a[DW-1], cmd_a} - {cmd_b[DW-1], cmd_b};
        end
    end

    // Stage 2: magnitude, scale, deadband and saturation. Saturation is decided on the
    // full-width value so large magnitudes cannot alias into small duties.
    logic [DW:0]       abs_v;
    logic [DW:0]       m_v;
    logic [DUTY_W-1:0] tgt_d, tgt_q;
    logic              sgn_d, sgn_q;

    always_comb begin
        abs_v = diff_q[DW] ? -diff_q : diff_q;
        m_v   = abs_v >> SHIFT;
        tgt_d = tgt_q;
        sgn_d = sgn_q;
        if (!en) begin
            tgt_d = '0;
            sgn_d = 1'b0;
        end else if (s2_en) begin
            sgn_d = diff_q[DW];
            if (m_v < (DW+1)'(deadband)) begin
                tgt_d = '0;
            end else if (m_v > (DW+1)'(DUTY_MAX)) begin
                tgt_d = DUTY_W'(DUTY_MAX);
            end else begin
                tgt_d = DUTY_W'(m_v);
            end
        end
    end

    // Stage 3: bridge FSM and slew-limited magnitude.
    chan_state_e       state_d, state_q;
    logic [DUTY_W-1:0] mag_d, mag_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [DUTY_W-1:0] mag_to_tgt;
    logic [DUTY_W-1:0] mag_to0;
    logic [DUTY_W-1:0] mag_from0;
    logic              same_dir;
    chan_state_e       dir_state;

    assign mag_to_tgt = DUTY_W'(slew(SLEW_W'(mag_q), SLEW_W'(tgt_q), SLEW_W'(slew_step)));
    assign mag_to0    = DUTY_W'(slew(SLEW_W'(mag_q), '0,             SLEW_W'(slew_step)));
    assign mag_from0  = DUTY_W'(slew('0,             SLEW_W'(tgt_q), SLEW_W'(slew_step)));
    assign same_dir   = ((state_q == ST_FWD) && !sgn_q) || ((state_q == ST_REV) && sgn_q);
    assign dir_state  = sgn_q ? ST_REV : ST_FWD;

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = ST_IDLE;
            mag_d   = '0;
            cnt_d   = '0;
        end else if (s3_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (tgt_q != '0) begin
                        state_d = dir_state;
                        mag_d   = mag_from0;
                    end
                end
                ST_FWD, ST_REV: begin
                    if ((tgt_q != '0) && same_dir) begin
                        mag_d = mag_to_tgt;
                    end else begin
                        // Ramp down first; the bridge only goes dead once current is off.
                        mag_d = mag_to0;
                        if (mag_to0 == '0) begin
                            state_d = ST_DEAD;
                            cnt_d   = CNT_W'(DEAD_TICKS);
                        end
                    end
                end
                ST_DEAD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (tgt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = dir_state;
                        mag_d   = mag_from0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mag_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they land on the same edge as the FSM.
    logic [DUTY_W-1:0] duty_p_d, duty_p_q;
    logic [DUTY_W-1:0] duty_n_d, duty_n_q;
    logic              dir_d, dir_q;
    logic [DUTY_W-1:0] mag_floor;

    assign mag_floor = (mag_d > DUTY_MIN_V) ? mag_d : DUTY_MIN_V;

    always_comb begin
        duty_p_d = DUTY_MIN_V;
        duty_n_d = DUTY_MIN_V;
        dir_d    = 1'b0;
        case (state_d)
            ST_FWD:  duty_p_d = mag_floor;
            ST_REV: begin
                duty_n_d = mag_floor;
                dir_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            diff_q   <= '0;
            tgt_q    <= '0;
            sgn_q    <= 1'b0;
            state_q  <= ST_IDLE;
            mag_q    <= '0;
            cnt_q    <= '0;
            duty_p_q <= DUTY_MIN_V;
            duty_n_q <= DUTY_MIN_V;
            dir_q    <= 1'b0;
        end else begin
            diff_q   <= diff_d;
            tgt_q    <= tgt_d;
            sgn_q    <= sgn_d;
            state_q  <= state_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            duty_p_q <= duty_p_d;
            duty_n_q <= duty_n_d;
            dir_q    <= dir_d;
        end
    end

    assign duty_p = duty_p_q;
    assign duty_n = duty_n_q;
    assign dir    = dir_q;

endmodule

// File: rtl/motor_duty_mixer.sv
// Purpose: NCH-channel PID-difference to H-bridge duty mixer with shared strobe pipeline.
// Latency: 3 CLK from the UPD_STB edge to DUTY_P/DUTY_N/DIR and the VALID pulse.
// Backpressure: none; strobes may arrive every cycle, strobes with EN=0 are dropped.
// Ports: CLK, RST (async, active high), bus (slave side of motor_duty_mixer_if).
module motor_duty_mixer
    import motor_duty_mixer_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DW         = 32,
    parameter int DUTY_W     = 16,
    parameter int SHIFT      = 15,
    parameter int DUTY_MAX   = 9999,
    parameter int DUTY_MIN   = 1,
    parameter int DEAD_TICKS = 4
) (
    input  logic               CLK,
    input  logic               RST,
    motor_duty_mixer_if.slave  bus
);

    // Strobe pipeline shared by all channels; each bit marks a tick entering the next stage.
    logic s1_vld_d, s1_vld_q;
    logic s2_vld_d, s2_vld_q;
    logic valid_d,  valid_q;

    always_comb begin
        s1_vld_d = bus.EN & bus.UPD_STB;
        s2_vld_d = bus.EN & s1_vld_q;
        valid_d  = bus.EN & s2_vld_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            valid_q  <= valid_d;
        end
    end

    logic [NCH*DUTY_W-1:0] duty_p_w;
    logic [NCH*DUTY_W-1:0] duty_n_w;
    logic [NCH-1:0]        dir_w;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        duty_slew_chan #(
            .DW         (DW),
            .DUTY_W     (DUTY_W),
            .SHIFT      (SHIFT),
            .DUTY_MAX   (DUTY_MAX),
            .DUTY_MIN   (DUTY_MIN),
            .DEAD_TICKS (DEAD_TICKS)
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .en        (bus.EN),
            .s1_en     (bus.UPD_STB),
            .s2_en     (s1_vld_q),
            .s3_en     (s2_vld_q),
            .cmd_a     (bus.CMD_A[k*DW +: DW]),
            .cmd_b     (bus.CMD_B[k*DW +: DW]),
            .slew_step (bus.SLEW_STEP),
            .deadband  (bus.DEADBAND),
            .duty_p    (duty_p_w[k*DUTY_W +: DUTY_W]),
            .duty_n    (duty_n_w[k*DUTY_W +: DUTY_W]),
            .dir       (dir_w[k])
        );
    end

    assign bus.DUTY_P = duty_p_w;
    assign bus.DUTY_N = duty_n_w;
    assign bus.DIR    = dir_w;
    assign bus.VALID  = valid_q;

endmodule
